div_radix2: RTL and testbench

- Multi-cycle 32-bit signed/unsigned integer divider in the EX stage.
- Serves DIV and DIVU.
- Its busy indication drives the hazard unit's alu_stallE, which freezes F/D/E while an iteration is in progress.
- The result is a {remainder, quotient} pair written to HI/LO. The result is held until the pipeline actually advances past EX.

---
 rtl/div_radix2.sv | 135 +++++++++++++
 tb/tb_div_radix2.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/div_radix2.sv
// Restoring radix-2 signed/unsigned divider producing one quotient bit per cycle.
// The result is ready WIDTH+1 cycles after start and is held until pipe_hold drops.
module div_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             pipe_hold,
  input  logic             cancel,
  output logic             div_stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] pr_q, pr_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rmd_q, rmd_d;
  logic               valid_q, valid_d;

  logic [WIDTH:0]     trial_hi;
  logic               trial_ge;
  logic [WIDTH-1:0]   trial_diff;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_quo;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // Upper WIDTH+1 bits of the partial remainder after the left shift.
  assign trial_hi   = pr_q[2*WIDTH-1:WIDTH-1];
  assign trial_ge   = trial_hi >= {1'b0, dvs_q};
  assign trial_diff = trial_hi[WIDTH-1:0] - dvs_q;
  assign step_rem   = trial_ge ? trial_diff : trial_hi[WIDTH-1:0];
  assign step_quo   = {pr_q[WIDTH-2:0], trial_ge};

  assign a_mag = (signed_div && a[WIDTH-1]) ? -a : a;
  assign b_mag = (signed_div && b[WIDTH-1]) ? -b : b;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pr_d    = pr_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quot_d  = quot_q;
    rmd_d   = rmd_q;
    valid_d = valid_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pr_d    = {{WIDTH{1'b0}}, a_mag};
          dvs_d   = b_mag;
          qneg_d  = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d  = signed_div & a[WIDTH-1];
          count_d = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        pr_d    = {step_rem, step_quo};
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          quot_d  = qneg_q ? -step_quo : step_quo;
          rmd_d   = rneg_q ? -step_rem : step_rem;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Leaving DONE is the cycle HI/LO capture the held result.
        if (!pipe_hold) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    if (cancel) begin
      valid_d = 1'b0;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      pr_q    <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quot_q  <= '0;
      rmd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pr_q    <= pr_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quot_q  <= quot_d;
      rmd_q   <= rmd_d;
      valid_q <= valid_d;
    end
  end

  assign div_stall    = start & ~cancel & ((state_q == ST_IDLE) | (state_q == ST_BUSY));
  assign result_valid = valid_q;
  assign quotient     = quot_q;
  assign remainder    = rmd_q;

endmodule

// File: tb/tb_div_radix2.sv
// Directed bench for div_radix2: latency, signed fixes, corner cases, cancel, hold, async reset.
module tb_div_radix2;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        pipe_hold;
  logic        cancel;
  logic        div_stall;
  logic        result_valid;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_chk  = 0;
  int n_fail = 0;

  div_radix2 #(.WIDTH(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .signed_div   (signed_div),
    .a            (a),
    .b            (b),
    .pipe_hold    (pipe_hold),
    .cancel       (cancel),
    .div_stall    (div_stall),
    .result_valid (result_valid),
    .quotient     (quotient),
    .remainder    (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one divide with start held, counts stall cycles, checks result and DONE exit.
  task automatic run_div(input string tag, input logic sd, input logic [31:0] aa,
                         input logic [31:0] bb, input logic [31:0] eq, input logic [31:0] er);
    int cycles;
    signed_div = sd;
    a          = aa;
    b          = bb;
    start      = 1'b1;
    pipe_hold  = 1'b0;
    cycles     = 0;
    @(negedge clk);
    while (div_stall && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    check({tag, "_stall_len"}, cycles, 32'd33);
    check({tag, "_valid"}, {31'd0, result_valid}, 32'd1);
    check({tag, "_quot"}, quotient, eq);
    check({tag, "_rem"}, remainder, er);
    tick();
    start = 1'b0;
    a     = 32'hDEAD_BEEF;
    b     = 32'h1234_5678;
    @(negedge clk);
    check({tag, "_idle_valid"}, {31'd0, result_valid}, 32'd0);
    check({tag, "_idle_stall"}, {31'd0, div_stall}, 32'd0);
    tick();
  endtask

  initial begin
    logic stable;
    resetn     = 1'b0;
    start      = 1'b0;
    signed_div = 1'b0;
    a          = '0;
    b          = '0;
    pipe_hold  = 1'b0;
    cancel     = 1'b0;
    #12;
    check("rst_stall", {31'd0, div_stall}, 32'd0);
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_quot", quotient, 32'd0);
    check("rst_rem", remainder, 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    run_div("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    run_div("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2);
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_div("divu_by0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);

    // Cancel at BUSY cycle 10.
    signed_div = 1'b0;
    a          = 32'd100;
    b          = 32'd7;
    start      = 1'b1;
    repeat (10) tick();
    cancel = 1'b1;
    @(negedge clk);
    check("cancel_stall", {31'd0, div_stall}, 32'd0);
    tick();
    cancel = 1'b0;
    start  = 1'b0;
    repeat (30) tick();
    @(negedge clk);
    check("cancel_no_valid", {31'd0, result_valid}, 32'd0);
    tick();
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

    // pipe_hold from N+30 to N+40 with start held high throughout.
    signed_div = 1'b0;
    a          = 32'd100;
    b          = 32'd7;
    start      = 1'b1;
    repeat (30) tick();
    pipe_hold = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("hold_done_valid", {31'd0, result_valid}, 32'd1);
    check("hold_done_stall", {31'd0, div_stall}, 32'd0);
    check("hold_done_quot", quotient, 32'd14);
    check("hold_done_rem", remainder, 32'd2);
    stable = 1'b1;
    for (int i = 34; i <= 40; i++) begin
      tick();
      a = a + 32'd3;
      @(negedge clk);
      if (!(result_valid && !div_stall && quotient == 32'd14 && remainder == 32'd2))
        stable = 1'b0;
    end
    check("hold_stable", {31'd0, stable}, 32'd1);
    tick();
    pipe_hold = 1'b0;
    @(negedge clk);
    check("hold_release_valid", {31'd0, result_valid}, 32'd1);
    tick();
    start = 1'b0;
    @(negedge clk);
    check("hold_exit_valid", {31'd0, result_valid}, 32'd0);
    tick();

    // Asynchronous reset in the middle of BUSY, between edges.
    a     = 32'd1000;
    b     = 32'd3;
    start = 1'b1;
    repeat (5) tick();
    #2;
    resetn = 1'b0;
    start  = 1'b0;
    #1;
    check("arst_stall", {31'd0, div_stall}, 32'd0);
    check("arst_valid", {31'd0, result_valid}, 32'd0);
    check("arst_quot", quotient, 32'd0);
    check("arst_rem", remainder, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    run_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'h0000_000F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
